// File: rtl/ssm_pkg.sv
// ssm_pkg: scheduler state encoding and derived-width helpers
package ssm_pkg;

    typedef enum logic [2:0] {IDLE, PULSE, WAIT, WRITE, NEXT, FIN} state_e;

    // index width that never collapses to zero bits for single-tile axes
    function automatic int clog2_min1(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/ssm_tile_addr_gen.sv
// ssm_tile_addr_gen: tile row/column counters and flat write-back base address
module ssm_tile_addr_gen import ssm_pkg::*; #(
    parameter int H = 24,
    parameter int P = 64,
    parameter int H_TILE = 1,
    parameter int P_TILE = 1,
    localparam int NUM_TILE_H = H / H_TILE,
    localparam int NUM_TILE_P = P / P_TILE,
    localparam int HW = clog2_min1(NUM_TILE_H),
    localparam int PW = clog2_min1(NUM_TILE_P),
    localparam int AW = $clog2(H * P)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          clr,
    input  logic          adv,
    output logic [HW-1:0] h_idx,
    output logic [PW-1:0] p_idx,
    output logic [AW-1:0] wb_base,
    output logic          last
);

    logic [HW-1:0] h_idx_q, h_idx_d;
    logic [PW-1:0] p_idx_q, p_idx_d;
    logic          p_wrap, h_wrap;

    // column advances first; row only steps on column wrap and holds on the final tile
    always_comb begin
        p_wrap  = p_idx_q == PW'(NUM_TILE_P - 1);
        h_wrap  = h_idx_q == HW'(NUM_TILE_H - 1);
        p_idx_d = clr ? '0 : !adv ? p_idx_q : p_wrap ? '0 : p_idx_q + 1'b1;
        h_idx_d = clr ? '0 : (adv && p_wrap && !h_wrap) ? h_idx_q + 1'b1 : h_idx_q;
    end

    // index registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            h_idx_q <= '0;
            p_idx_q <= '0;
        end else begin
            h_idx_q <= h_idx_d;
            p_idx_q <= p_idx_d;
        end
    end

    assign h_idx   = h_idx_q;
    assign p_idx   = p_idx_q;
    assign last    = p_wrap && h_wrap;
    assign wb_base = AW'(h_idx_q) * AW'(H_TILE * P) + AW'(p_idx_q) * AW'(P_TILE);

endmodule

// File: rtl/ssm_tile_scheduler.sv
// ssm_tile_scheduler: sweeps H x P in tiles, handshaking each tile with the datapath
// Optional watchdog on tile_done enabled by defining SSM_TILE_TIMEOUT_EN.
module ssm_tile_scheduler import ssm_pkg::*; #(
    parameter int H = 24,
    parameter int P = 64,
    parameter int H_TILE = 1,
    parameter int P_TILE = 1,
    parameter int TIMEOUT = 4096,
    localparam int NUM_TILE_H = H / H_TILE,
    localparam int NUM_TILE_P = P / P_TILE,
    localparam int HW = clog2_min1(NUM_TILE_H),
    localparam int PW = clog2_min1(NUM_TILE_P),
    localparam int AW = $clog2(H * P),
    localparam int TW = $clog2(NUM_TILE_H * NUM_TILE_P + 1)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic          abort,
    input  logic          tile_done,
    output logic          tile_start,
    output logic [HW-1:0] h_idx,
    output logic [PW-1:0] p_idx,
    output logic          wb_en,
    output logic [AW-1:0] wb_base,
    output logic [TW-1:0] tile_cnt,
    output logic          busy,
    output logic          done,
    output logic          err_timeout
);

    if (H % H_TILE != 0 || P % P_TILE != 0 || TIMEOUT < 1) begin : g_bad_cfg
        $fatal(1, "ssm_tile_scheduler: H_TILE/P_TILE must divide H/P and TIMEOUT must be positive");
    end

    state_e        state_q, state_d;
    logic [TW-1:0] tile_cnt_q, tile_cnt_d;
    logic          go, adv, last, timeout_hit;

    assign go  = state_q == IDLE && start && !abort;
    assign adv = state_q == NEXT && !abort;

    // next state and tile counter; abort overrides everything outside IDLE
    always_comb begin
        state_d    = state_q;
        tile_cnt_d = go ? '0 : tile_cnt_q;
        unique case (state_q)
            IDLE:    state_d = go ? PULSE : IDLE;
            PULSE:   state_d = WAIT;
            WAIT:    state_d = tile_done ? WRITE : timeout_hit ? IDLE : WAIT;
            WRITE:   begin
                state_d    = NEXT;
                tile_cnt_d = tile_cnt_q + 1'b1;
            end
            NEXT:    state_d = last ? FIN : PULSE;
            FIN:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
        if (abort && state_q != IDLE) begin
            state_d    = IDLE;
            tile_cnt_d = tile_cnt_q;
        end
    end

    // state and tile counter registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            tile_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            tile_cnt_q <= tile_cnt_d;
        end
    end

`ifdef SSM_TILE_TIMEOUT_EN
    localparam int CW = clog2_min1(TIMEOUT);
    logic [CW-1:0] wait_cnt_q, wait_cnt_d;
    logic          err_timeout_q, err_timeout_d;

    // wait counter is zero outside WAIT, so it restarts on every WAIT entry
    always_comb begin
        wait_cnt_d    = state_q == WAIT ? wait_cnt_q + 1'b1 : '0;
        timeout_hit   = state_q == WAIT && wait_cnt_q == CW'(TIMEOUT - 1) && !tile_done && !abort;
        err_timeout_d = go ? 1'b0 : timeout_hit ? 1'b1 : err_timeout_q;
    end

    // watchdog registers; the error flag is sticky until an accepted start
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wait_cnt_q    <= '0;
            err_timeout_q <= 1'b0;
        end else begin
            wait_cnt_q    <= wait_cnt_d;
            err_timeout_q <= err_timeout_d;
        end
    end

    assign err_timeout = err_timeout_q;
`else
    assign timeout_hit = 1'b0;
    assign err_timeout = 1'b0;
`endif

    ssm_tile_addr_gen #(
        .H      (H),
        .P      (P),
        .H_TILE (H_TILE),
        .P_TILE (P_TILE)
    ) u_addr_gen (
        .clk     (clk),
        .rst     (rst),
        .clr     (go),
        .adv     (adv),
        .h_idx   (h_idx),
        .p_idx   (p_idx),
        .wb_base (wb_base),
        .last    (last)
    );

    assign tile_start = state_q == PULSE;
    assign wb_en      = state_q == WRITE;
    assign done       = state_q == FIN;
    assign busy       = state_q != IDLE;
    assign tile_cnt   = tile_cnt_q;

endmodule

// File: tb/tb_ssm_tile_scheduler.sv
// tb_ssm_tile_scheduler: directed scoreboard bench for ssm_tile_scheduler
module tb_ssm_tile_scheduler;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_fail = 0;

    `define CHK(tag, obs, exp) begin n_cmp++; assert ((obs) === (exp)) else begin n_fail++; $error("FAIL %s: observed %0d, expected %0d", tag, (obs), (exp)); end end

    // 4x4 array in 2x2 tiles: four tiles
    logic a_start = 0, a_abort = 0, a_tdone = 0;
    logic a_ts, a_wb, a_busy, a_done, a_err;
    logic [0:0] a_h, a_p;
    logic [3:0] a_base;
    logic [2:0] a_cnt;

    ssm_tile_scheduler #(.H(4), .P(4), .H_TILE(2), .P_TILE(2)) dut_a (
        .clk(clk), .rst(rst), .start(a_start), .abort(a_abort), .tile_done(a_tdone),
        .tile_start(a_ts), .h_idx(a_h), .p_idx(a_p), .wb_en(a_wb), .wb_base(a_base),
        .tile_cnt(a_cnt), .busy(a_busy), .done(a_done), .err_timeout(a_err)
    );

    // default parameters: 24 x 64 single-element tiles
    logic b_start = 0, b_abort = 0, b_tdone = 0;
    logic b_ts, b_wb, b_busy, b_done, b_err;
    logic [4:0] b_h;
    logic [5:0] b_p;
    logic [10:0] b_base;
    logic [10:0] b_cnt;

    ssm_tile_scheduler dut_b (
        .clk(clk), .rst(rst), .start(b_start), .abort(b_abort), .tile_done(b_tdone),
        .tile_start(b_ts), .h_idx(b_h), .p_idx(b_p), .wb_en(b_wb), .wb_base(b_base),
        .tile_cnt(b_cnt), .busy(b_busy), .done(b_done), .err_timeout(b_err)
    );

    // single tile covering the whole 2x2 array
    logic c_start = 0, c_abort = 0, c_tdone = 0;
    logic c_ts, c_wb, c_busy, c_done, c_err;
    logic [0:0] c_h, c_p;
    logic [1:0] c_base;
    logic [0:0] c_cnt;

    ssm_tile_scheduler #(.H(2), .P(2), .H_TILE(2), .P_TILE(2)) dut_c (
        .clk(clk), .rst(rst), .start(c_start), .abort(c_abort), .tile_done(c_tdone),
        .tile_start(c_ts), .h_idx(c_h), .p_idx(c_p), .wb_en(c_wb), .wb_base(c_base),
        .tile_cnt(c_cnt), .busy(c_busy), .done(c_done), .err_timeout(c_err)
    );

    // watchdog instance: 4-tile config, TIMEOUT=16
    logic t_start = 0, t_abort = 0, t_tdone = 0;
    logic t_ts, t_wb, t_busy, t_done, t_err;
    logic [0:0] t_h, t_p;
    logic [3:0] t_base;
    logic [2:0] t_cnt;

    ssm_tile_scheduler #(.H(4), .P(4), .H_TILE(2), .P_TILE(2), .TIMEOUT(16)) dut_t (
        .clk(clk), .rst(rst), .start(t_start), .abort(t_abort), .tile_done(t_tdone),
        .tile_start(t_ts), .h_idx(t_h), .p_idx(t_p), .wb_en(t_wb), .wb_base(t_base),
        .tile_cnt(t_cnt), .busy(t_busy), .done(t_done), .err_timeout(t_err)
    );

    int qa[$];
    int qb[$];
    logic [3:0] qc[$];

    int dly_a = 5, age_a = 0, na_ts = 0, na_wb = 0, na_done = 0, exp_a;
    bit arm_a = 0;
    int age_b = 0, nb_ts = 0, nb_wb = 0, nb_done = 0, cyc_b = 0, td_b = -1, bad_gap = 0, last_b = -1, exp_b;
    bit arm_b = 0;
    int nw, nd;

    // one cycle of dut_a: observe at negedge, score write-backs, answer tile_start after dly_a cycles
    task automatic step_a();
        @(negedge clk);
        a_start = 0;
        a_abort = 0;
        a_tdone = 0;
        if (a_wb) begin
            exp_a = qa.size() != 0 ? qa.pop_front() : -1;
            `CHK("a wb_base", int'(a_base), exp_a)
            na_wb++;
        end
        if (a_done) na_done++;
        if (a_ts) begin
            na_ts++;
            age_a = 0;
            arm_a = 1;
        end else if (arm_a) begin
            age_a++;
            if (age_a == dly_a) begin
                a_tdone = 1;
                arm_a = 0;
            end
        end
    endtask

    // one cycle of dut_b: tile_done one cycle after tile_start, measure tile_done-to-tile_start gap
    task automatic step_b();
        @(negedge clk);
        b_start = 0;
        b_tdone = 0;
        cyc_b++;
        if (b_wb) begin
            exp_b = qb.size() != 0 ? qb.pop_front() : -1;
            `CHK("b wb_base", int'(b_base), exp_b)
            last_b = int'(b_base);
            nb_wb++;
        end
        if (b_done) nb_done++;
        if (b_ts) begin
            nb_ts++;
            if (td_b >= 0 && cyc_b - td_b != 3) bad_gap++;
            age_b = 0;
            arm_b = 1;
        end else if (arm_b) begin
            age_b++;
            if (age_b == 1) begin
                b_tdone = 1;
                td_b = cyc_b;
                arm_b = 0;
            end
        end
    endtask

    task automatic push_a();
        for (int h = 0; h < 2; h++)
            for (int p = 0; p < 2; p++)
                qa.push_back(h * 2 * 4 + p * 2);
    endtask

    initial begin
        repeat (3) @(negedge clk);
        `CHK("reset tile_start", a_ts, 1'b0)
        `CHK("reset wb_en", a_wb, 1'b0)
        `CHK("reset wb_base", a_base, 4'd0)
        `CHK("reset h_idx", a_h, 1'b0)
        `CHK("reset p_idx", a_p, 1'b0)
        `CHK("reset tile_cnt", a_cnt, 3'd0)
        `CHK("reset busy", a_busy, 1'b0)
        `CHK("reset done", a_done, 1'b0)
        `CHK("reset err_timeout", a_err, 1'b0)
        rst = 0;

        // four-tile sweep, tile_done 5 cycles after each tile_start
        dly_a = 5;
        push_a();
        step_a();
        a_start = 1;
        for (int i = 0; i < 200 && na_done == 0; i++) step_a();
        step_a();
        `CHK("sweep tile_start pulses", na_ts, 4)
        `CHK("sweep wb_en pulses", na_wb, 4)
        `CHK("sweep done pulses", na_done, 1)
        `CHK("sweep tile_cnt", a_cnt, 3'd4)
        `CHK("sweep busy after", a_busy, 1'b0)
        `CHK("sweep scoreboard drained", qa.size(), 0)
        repeat (3) step_a();
        `CHK("sweep tile_cnt holds", a_cnt, 3'd4)

        // tile_done while idle must not start anything
        a_tdone = 1;
        step_a();
        `CHK("idle tile_done busy", a_busy, 1'b0)
        `CHK("idle tile_done wb_en", a_wb, 1'b0)

        // abort during the third WAIT
        dly_a = 3;
        na_ts = 0; na_wb = 0; na_done = 0;
        push_a();
        step_a();
        a_start = 1;
        for (int i = 0; i < 100 && na_ts < 3; i++) step_a();
        step_a();
        `CHK("abort in WAIT busy", a_busy, 1'b1)
        a_abort = 1;
        arm_a = 0;
        step_a();
        `CHK("abort busy", a_busy, 1'b0)
        `CHK("abort tile_cnt", a_cnt, 3'd2)
        `CHK("abort h_idx held", a_h, 1'b1)
        `CHK("abort p_idx held", a_p, 1'b0)
        `CHK("abort tile_start", a_ts, 1'b0)
        repeat (5) step_a();
        `CHK("abort no done", na_done, 0)
        qa.delete();
        na_ts = 0; na_wb = 0; na_done = 0;
        push_a();
        a_start = 1;
        step_a();
        `CHK("restart tile_start", a_ts, 1'b1)
        `CHK("restart h_idx", a_h, 1'b0)
        `CHK("restart p_idx", a_p, 1'b0)
        `CHK("restart tile_cnt", a_cnt, 3'd0)
        for (int i = 0; i < 200 && na_done == 0; i++) step_a();
        `CHK("restart tile_start pulses", na_ts, 4)
        `CHK("restart scoreboard drained", qa.size(), 0)

        // abort and start together in IDLE
        step_a();
        a_start = 1;
        a_abort = 1;
        step_a();
        `CHK("abort beats start busy", a_busy, 1'b0)
        `CHK("abort beats start tile_start", a_ts, 1'b0)

        // asynchronous reset in the middle of WRITE
        dly_a = 2;
        push_a();
        step_a();
        a_start = 1;
        for (int i = 0; i < 100 && !a_wb; i++) step_a();
        #1 rst = 1;
        #1;
        `CHK("rst mid-write wb_en", a_wb, 1'b0)
        `CHK("rst mid-write busy", a_busy, 1'b0)
        `CHK("rst mid-write tile_start", a_ts, 1'b0)
        `CHK("rst mid-write done", a_done, 1'b0)
        `CHK("rst mid-write wb_base", a_base, 4'd0)
        `CHK("rst mid-write h_idx", a_h, 1'b0)
        `CHK("rst mid-write p_idx", a_p, 1'b0)
        `CHK("rst mid-write tile_cnt", a_cnt, 3'd0)
        `CHK("rst mid-write err_timeout", a_err, 1'b0)
        step_a();
        rst = 0;
        arm_a = 0;
        qa.delete();

        // start pulse during WAIT is ignored
        dly_a = 4;
        na_ts = 0; na_wb = 0; na_done = 0;
        push_a();
        step_a();
        a_start = 1;
        step_a();
        step_a();
        a_start = 1;
        step_a();
        `CHK("start in WAIT busy", a_busy, 1'b1)
        `CHK("start in WAIT tile_start", a_ts, 1'b0)
        `CHK("start in WAIT tile_cnt", a_cnt, 3'd0)
        `CHK("start in WAIT p_idx", a_p, 1'b0)
        for (int i = 0; i < 200 && na_done == 0; i++) step_a();
        repeat (10) step_a();
        `CHK("start in WAIT tile_start pulses", na_ts, 4)
        `CHK("start in WAIT done pulses", na_done, 1)
        `CHK("start in WAIT tile_cnt", a_cnt, 3'd4)
        `CHK("start in WAIT scoreboard drained", qa.size(), 0)

        // single tile: PULSE, WAIT, WRITE, NEXT, FIN, IDLE as {tile_start, wb_en, done, busy}
        qc.push_back(4'b1001);
        qc.push_back(4'b0001);
        qc.push_back(4'b0101);
        qc.push_back(4'b0001);
        qc.push_back(4'b0011);
        qc.push_back(4'b0000);
        @(negedge clk);
        c_start = 1;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            c_start = 0;
            `CHK("single-tile sequence", {c_ts, c_wb, c_done, c_busy}, qc.pop_front())
            if (c_wb) `CHK("single-tile wb_base", c_base, 2'd0)
            c_tdone = (i == 1);
        end
        `CHK("single-tile tile_cnt", c_cnt, 1'b1)

        // default parameters, tile_done one cycle after each tile_start
        for (int h = 0; h < 24; h++)
            for (int p = 0; p < 64; p++)
                qb.push_back(h * 1 * 64 + p * 1);
        step_b();
        b_start = 1;
        for (int i = 0; i < 8000 && nb_done == 0; i++) step_b();
        step_b();
        `CHK("default wb_en pulses", nb_wb, 1536)
        `CHK("default tile_start pulses", nb_ts, 1536)
        `CHK("default last wb_base", last_b, 1535)
        `CHK("default done pulses", nb_done, 1)
        `CHK("default 3-cycle gap violations", bad_gap, 0)
        `CHK("default tile_cnt", b_cnt, 11'd1536)
        `CHK("default busy after", b_busy, 1'b0)
        `CHK("default scoreboard drained", qb.size(), 0)

`ifdef SSM_TILE_TIMEOUT_EN
        // watchdog: tile_done never arrives
        @(negedge clk);
        t_start = 1;
        @(negedge clk);
        t_start = 0;
        nw = 0;
        nd = 0;
        for (int i = 0; i < 100 && t_busy; i++) begin
            @(negedge clk);
            if (t_busy && !t_ts) nw++;
            if (t_done) nd++;
        end
        `CHK("timeout WAIT cycles", nw, 16)
        `CHK("timeout err_timeout", t_err, 1'b1)
        `CHK("timeout busy", t_busy, 1'b0)
        `CHK("timeout no done", nd, 0)
        repeat (3) @(negedge clk);
        `CHK("timeout err sticky", t_err, 1'b1)
        t_start = 1;
        @(negedge clk);
        t_start = 0;
        `CHK("timeout err cleared by start", t_err, 1'b0)
        t_abort = 1;
        @(negedge clk);
        t_abort = 0;
        `CHK("timeout cleanup abort", t_busy, 1'b0)
`else
        // without the watchdog WAIT holds indefinitely
        @(negedge clk);
        t_start = 1;
        @(negedge clk);
        t_start = 0;
        nd = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (t_done) nd++;
        end
        `CHK("no watchdog still busy", t_busy, 1'b1)
        `CHK("no watchdog err_timeout", t_err, 1'b0)
        `CHK("no watchdog no done", nd, 0)
        t_abort = 1;
        @(negedge clk);
        t_abort = 0;
        `CHK("no watchdog abort", t_busy, 1'b0)
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/ssm_tile_scheduler.md
SSM_TILE_SCHEDULER -- requirements
Module: ssm_tile_scheduler

Interface
REQ-001 The module SHALL have these parameters (name, default, meaning):
  H, 24, number of heads.
  P, 64, head dimension.
  H_TILE, 1, heads per tile.
  P_TILE, 1, head-dim elements per tile.
  TIMEOUT, 4096, maximum cycles to wait for tile_done.
REQ-002 The module SHALL use these derived constants: NUM_TILE_H=H/H_TILE; NUM_TILE_P=P/P_TILE; HW=max(1,$clog2(NUM_TILE_H)); PW=max(1,$clog2(NUM_TILE_P)); AW=$clog2(H*P); TW=$clog2(NUM_TILE_H*NUM_TILE_P+1).
REQ-003 The module SHALL have these ports (name, direction, width, meaning):
  clk, in, 1, the only clock.
  rst, in, 1, asynchronous active-high reset.
  start, in, 1, pulse that launches a full H x P sweep.
  abort, in, 1, cancels the sweep.
  tile_done, in, 1, datapath tile completion.
  tile_start, out, 1, one-cycle pulse to the datapath.
  h_idx, out, HW, current tile row.
  p_idx, out, PW, current tile column.
  wb_en, out, 1, write-back strobe for y_tile.
  wb_base, out, AW, flat y element index of tile element 0.
  tile_cnt, out, TW, tiles completed.
  busy, out, 1, sweep in progress.
  done, out, 1, one-cycle sweep-complete pulse.
  err_timeout, out, 1, sticky watchdog flag.

Function
REQ-004 The FSM SHALL use states IDLE, PULSE, WAIT, WRITE, NEXT and FIN, all registered.
REQ-005 IDLE with start=1: next cycle state=PULSE, h_idx=p_idx=0, tile_cnt=0, err_timeout cleared, tile_start=1.
REQ-006 PULSE: tile_start SHALL be high for exactly this one cycle; the next state is WAIT.
REQ-007 WAIT: tile_done=1 goes to WRITE; tile_done sampled in any other state SHALL be ignored.
REQ-008 WRITE: wb_en=1 for exactly one cycle; wb_base=h_idx*H_TILE*P+p_idx*P_TILE, stable while wb_en=1; tile_cnt increments; the next state is NEXT.
REQ-009 NEXT: p_idx advances first.
  If p_idx<NUM_TILE_P-1: p_idx+1, then PULSE.
  Else p_idx=0; if h_idx<NUM_TILE_H-1: h_idx+1, then PULSE; else FIN.
REQ-010 FIN: done=1 for one cycle, then IDLE; tile_cnt holds NUM_TILE_H*NUM_TILE_P until the next start.
REQ-011 busy SHALL be 1 in every state except IDLE.
REQ-012 start while busy SHALL be ignored.
REQ-013 Per-tile latency from tile_done to the next tile_start SHALL be 3 cycles (WRITE, NEXT, PULSE).
REQ-014 abort=1 in any non-IDLE state SHALL force IDLE on the next edge with tile_start=wb_en=done=0; h_idx, p_idx and tile_cnt hold their values.
REQ-015 abort and start together in IDLE: abort wins and no sweep starts.
REQ-016 A single-tile configuration (H_TILE=H, P_TILE=P) SHALL go PULSE->WAIT->WRITE->NEXT->FIN.

Reset
REQ-017 rst=1 SHALL asynchronously set state=IDLE and all outputs to 0 (tile_start, wb_en, wb_base, h_idx, p_idx, tile_cnt, busy, done, err_timeout), including mid-sweep.
REQ-018 After reset deassertion, the first start SHALL behave per REQ-005.

Configuration
REQ-019 With SSM_TILE_TIMEOUT_EN defined, a wait counter SHALL clear on entering WAIT and increment each WAIT cycle. If it reaches TIMEOUT-1 with tile_done=0, err_timeout is set (sticky until the next accepted start or reset) and the state goes to IDLE without done.
REQ-020 Without SSM_TILE_TIMEOUT_EN, WAIT SHALL wait indefinitely, no counter logic SHALL exist, and err_timeout is tied to 0.

Structure
REQ-021 The state enum and the derived-width helper functions SHALL live in the shared package ssm_pkg.
REQ-022 The index/address generation (h_idx, p_idx, wb_base) SHALL be a sub-module ssm_tile_addr_gen; the FSM stays in ssm_tile_scheduler.
REQ-023 The build SHALL fail elaboration if H%H_TILE!=0 or P%P_TILE!=0.

Verification
REQ-024 The bench SHALL cover at least these scenarios:
  - Sweep: H=4, P=4, H_TILE=2, P_TILE=2, start, tile_done 5 cycles after each tile_start -> exactly 4 tile_start pulses; wb_base 0, 2, 8, 10; tile_cnt=4; one done pulse.
  - Default parameters, tile_done 1 cycle after each tile_start -> 1536 wb_en pulses; last wb_base=1535; done once; 3-cycle tile_done-to-tile_start gap.
  - Abort during the 3rd WAIT (4-tile config) -> IDLE next cycle; tile_cnt=2; no done; a new start restarts at h_idx=p_idx=0.
  - Macro on, TIMEOUT=16, tile_done never asserted -> err_timeout=1 after 16 WAIT cycles; busy=0; done never asserted.
  - rst pulsed mid-WRITE -> all outputs 0 immediately; a start pulse during WAIT is ignored (no second sweep, counters unaffected).
